sdpram_clr_pipe: RTL and testbench
==================================

# sdpram_clr_pipe

Parametrised simple-dual-port RAM with a built-in clear engine, runtime re-clear request, configurable read latency and valid-tagged read data. It is the next generation of our self-initialising SDPRAM wrappers and sits under table and state stores that need a known memory image both after reset and on demand. The block uses a behavioural inferred array, so it carries no vendor primitive.

## Interface
- RAM_WIDTH, 72: data width in bits.
- RAM_DEPTH, 128: number of words. Any value ≥ 2; need not be a power of two.
- ADDR_WIDTH, $clog2(RAM_DEPTH): address width.
- LATENCY, 2: read latency in cycles, 1..4.
- INIT_VALUE, {RAM_WIDTH{1'b0}}: word written by the clear engine.
- INIT_ON_RESET, 1: 1 starts a clear automatically after reset; 0 goes straight to READY.
- clk, in, 1: the single clock.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- wr_en, in, 1: write strobe.
- wr_addr, in, ADDR_WIDTH: write address.
- wr_data, in, RAM_WIDTH: write data.
- rd_en, in, 1: read strobe.
- rd_addr, in, ADDR_WIDTH: read address.
- rd_data, out, RAM_WIDTH: read data.
- rd_valid, out, 1: rd_data qualifier.
- clr_req, in, 1: request a full clear; single-cycle pulse or level.
- clr_busy, out, 1: clear engine active.
- init_done, out, 1: memory holds a complete known image.
- wr_drop, out, 1: one-cycle pulse when a user write is discarded.

## Operation
- States:
  - RST: held while rst_n = 0.
  - CLEAR.
  - READY.
- Transitions:
  - RST → CLEAR if INIT_ON_RESET = 1, otherwise RST → READY.
  - READY → CLEAR on clr_req = 1.
  - CLEAR → READY after the word at address RAM_DEPTH−1 is written.
- Clear engine:
  - Counter runs 0..RAM_DEPTH−1 and writes INIT_VALUE to one word per cycle.
  - A clear takes exactly RAM_DEPTH cycles.
- clr_req while in CLEAR is ignored; it does not restart the sweep.
- clr_busy = 1 exactly in CLEAR.
- init_done:
  - Falls on entry to CLEAR.
  - Rises on entry to READY when that entry comes from CLEAR.
  - Stays 0 if INIT_ON_RESET = 0 until the first completed clear.
- User writes:
  - In READY, wr_en with wr_addr < RAM_DEPTH commits.
  - In CLEAR, wr_en is discarded and wr_drop pulses on the next cycle.
  - wr_addr ≥ RAM_DEPTH is also discarded with a wr_drop pulse.
- User reads:
  - Accepted in every state except RST.
  - A read issued in CLEAR, or with rd_addr ≥ RAM_DEPTH, returns INIT_VALUE.
- Memory contents are not affected by rst_n. After an async reset mid-clear, the counter restarts from 0.

## Timing
- Reset values:
  - rd_data = 0.
  - rd_valid = 0.
  - clr_busy = 0.
  - init_done = 0.
  - wr_drop = 0.
- First cycle after rst_n deassertion: clr_busy = 1 if INIT_ON_RESET = 1.
- Read latency: rd_en at cycle N gives rd_valid = 1 and rd_data at cycle N+LATENCY.
  - The array read is registered at N+1.
  - LATENCY−1 further output stages follow.
  - Fully pipelined: one read per cycle.
- rd_valid is 0 when no read was issued LATENCY cycles earlier. rd_data holds its last value while rd_valid = 0.
- Write visibility:
  - A write at cycle N is visible to reads issued at N+1 onward.
  - A same-cycle, same-address read at N returns the old word, unless the bypass option below is compiled in.
- Clear timing:
  - clr_req sampled high at cycle N in READY gives clr_busy = 1 and init_done = 0 at N+1.
  - Sweep writes occur during cycles N+1..N+RAM_DEPTH.
  - At N+RAM_DEPTH+1: clr_busy = 0 and init_done = 1.
- clr_req and wr_en in the same READY cycle: the write commits, then the clear overwrites it.

## Configuration
- Macro: SDPRAM_CLR_PIPE_WR_BYPASS_EN.
- Defined: a read at cycle N with rd_addr == wr_addr and a committing write at N returns wr_data at N+LATENCY (write-first forwarding).
- Undefined: the same read returns the pre-write word (read-first). There is no forwarding logic.

## Test plan
- Reset with INIT_ON_RESET = 1, RAM_DEPTH = 128, INIT_VALUE = 'h5A, then read all addresses → clr_busy high for exactly 128 cycles, init_done rises at cycle 129, every read returns 'h5A with rd_valid at +LATENCY.
- Back-to-back reads, LATENCY = 3, addresses 0..9 written with values addr+1 → rd_valid held high for 10 consecutive cycles, data 1..10 in order, 3 cycles after each rd_en.
- clr_req in READY while wr_en is driven through the clear → wr_drop pulses once per dropped write, init_done low for 128 cycles, and post-clear reads return INIT_VALUE.
- Same-cycle write 'hABC to addr 7 (old word 'h111) with a read of addr 7 → 'h111 without the macro, 'hABC with SDPRAM_CLR_PIPE_WR_BYPASS_EN.
- RAM_DEPTH = 100: write to addr 110 and read addr 110 → wr_drop pulses, read returns INIT_VALUE, addr 99 read/write works normally.
- rst_n asserted at clear cycle 50 → all outputs return to reset values asynchronously; after release the sweep restarts at address 0 and completes in RAM_DEPTH cycles.

Source files
------------

// File: rtl/sdpram_clr_pipe.sv
// Simple-dual-port RAM with a clear engine, runtime re-clear and a LATENCY-stage read pipeline.
// Optional macro SDPRAM_CLR_PIPE_WR_BYPASS_EN enables write-first forwarding on same-address read/write.
module sdpram_clr_pipe #(
    parameter int                   RAM_WIDTH     = 72,
    parameter int                   RAM_DEPTH     = 128,
    parameter int                   ADDR_WIDTH    = $clog2(RAM_DEPTH),
    parameter int                   LATENCY       = 2,
    parameter logic [RAM_WIDTH-1:0] INIT_VALUE    = {RAM_WIDTH{1'b0}},
    parameter bit                   INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [RAM_WIDTH-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [RAM_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  init_done,
    output logic                  wr_drop
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < DEPTH_EXT);
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_nxt_s;
    logic                    done_nxt_s;
    logic                    wr_commit_s;
    logic                    rd_accept_s;
    logic [RAM_WIDTH-1:0]    rd_word_s;
    logic [RAM_WIDTH-1:0]    mem_r [RAM_DEPTH];
    logic [RAM_WIDTH-1:0]    pipe_d_r [LATENCY];
    logic [LATENCY-1:0]      pipe_v_r;

    // Next-state logic for the RST/CLEAR/READY controller and its sweep counter.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        done_nxt_s    = init_done;
        case (state_r)
            ST_RST: begin
                clr_cnt_nxt_s = '0;
                if (INIT_ON_RESET) begin
                    state_nxt_s = ST_CLEAR;
                    done_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            ST_CLEAR: begin
                // clr_req is deliberately not looked at here: a sweep never restarts.
                if (clr_cnt_r == LAST_ADDR) begin
                    state_nxt_s   = ST_READY;
                    clr_cnt_nxt_s = '0;
                    done_nxt_s    = 1'b1;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = '0;
                    done_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s   = ST_READY;
                end
            end
            default: begin
                state_nxt_s   = ST_RST;
                clr_cnt_nxt_s = '0;
                done_nxt_s    = 1'b0;
            end
        endcase
    end

    // User write qualification and read-port word selection.
    always_comb begin
        wr_commit_s = wr_en && (state_r == ST_READY) && addr_in_range(wr_addr);
        rd_accept_s = rd_en && (state_r != ST_RST);
        if ((state_r == ST_READY) && addr_in_range(rd_addr)) begin
            rd_word_s = mem_r[rd_addr];
`ifdef SDPRAM_CLR_PIPE_WR_BYPASS_EN
            if (wr_commit_s && (wr_addr == rd_addr)) begin
                rd_word_s = wr_data;
            end else begin
                rd_word_s = mem_r[rd_addr];
            end
`endif
        end else begin
            rd_word_s = INIT_VALUE;
        end
    end

    // Controller state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RST;
            clr_cnt_r <= '0;
            clr_busy  <= 1'b0;
            init_done <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            clr_busy  <= (state_nxt_s == ST_CLEAR);
            init_done <= done_nxt_s;
            wr_drop   <= wr_en && !wr_commit_s;
        end
    end

    // Storage array; deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= INIT_VALUE;
        end else if (wr_commit_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read pipeline: stage 0 registers the array word, later stages only advance valid data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_r <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_d_r[k] <= '0;
            end
        end else begin
            pipe_v_r[0] <= rd_accept_s;
            if (rd_accept_s) begin
                pipe_d_r[0] <= rd_word_s;
            end
            for (int k = 1; k < LATENCY; k++) begin
                pipe_v_r[k] <= pipe_v_r[k-1];
                if (pipe_v_r[k-1]) begin
                    pipe_d_r[k] <= pipe_d_r[k-1];
                end
            end
        end
    end

    assign rd_data  = pipe_d_r[LATENCY-1];
    assign rd_valid = pipe_v_r[LATENCY-1];

endmodule

// File: tb/tb_sdpram_clr_pipe.sv
// Self-checking bench for sdpram_clr_pipe: random and directed stimulus against a behavioural model.
module tb_sdpram_clr_pipe;

    localparam int              W    = 16;
    localparam int              D    = 100;
    localparam int              AW   = 7;
    localparam int              LAT  = 3;
    localparam logic [W-1:0]    INIT = 16'h005A;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          clr_req = 1'b0;
    logic          clr_busy;
    logic          init_done;
    logic          wr_drop;

    always #5 clk = ~clk;

    sdpram_clr_pipe #(
        .RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_WIDTH(AW), .LATENCY(LAT),
        .INIT_VALUE(INIT), .INIT_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_req(clr_req), .clr_busy(clr_busy), .init_done(init_done), .wr_drop(wr_drop)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: memory image, remaining clear cycles, and a queue of read results.
    logic [W-1:0] m_mem [D];
    int           m_left;
    bit           m_done;
    bit           m_rst_pend;
    bit           hist_v[$];
    logic [W-1:0] hist_d[$];
    logic [W-1:0] m_last;
    bit           exp_valid;
    bit           exp_drop;
    logic [W-1:0] exp_data;

    task automatic model_reset();
        m_left = 0; m_done = 1'b0; m_rst_pend = 1'b1; m_last = '0;
        exp_valid = 1'b0; exp_drop = 1'b0; exp_data = '0;
        hist_v.delete(); hist_d.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            hist_v.push_back(1'b0); hist_d.push_back('0);
        end
    endtask

    task automatic model_start_clear();
        m_left = D; m_done = 1'b0;
        for (int i = 0; i < D; i++) m_mem[i] = INIT;
    endtask

    // One clock: drive inputs, let the edge pass, advance the model, settle 1 time unit after the edge.
    task automatic tick(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                        input logic re, input logic [AW-1:0] ra, input logic cr);
        bit clearing, commit, acc;
        logic [W-1:0] rv;
        wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; clr_req = cr;
        clearing = (m_left > 0);
        acc      = re && !m_rst_pend;
        commit   = we && !m_rst_pend && !clearing && (int'(wa) < D);
        rv = INIT;
        if (acc && !clearing && (int'(ra) < D)) begin
            rv = m_mem[ra];
`ifdef SDPRAM_CLR_PIPE_WR_BYPASS_EN
            if (commit && (wa == ra)) rv = wd;
`endif
        end
        @(posedge clk);
        exp_drop = we && !commit;
        if (commit) m_mem[wa] = wd;
        if (m_rst_pend) begin
            m_rst_pend = 1'b0;
            model_start_clear();
        end else if (clearing) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (cr) begin
            model_start_clear();
        end
        hist_v.push_back(acc); hist_d.push_back(rv);
        exp_valid = hist_v.pop_front();
        exp_data  = hist_d.pop_front();
        if (exp_valid) m_last = exp_data;
        exp_data = m_last;
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2 * D && m_left > 0; i++) idle();
    endtask

    task automatic test_reset();
        int busy_cnt, rise_at;
        #2 rst_n = 1'b0;
        model_reset();
        #3;
        checks += 5;
        if (rd_data !== '0)     begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        if (clr_busy !== 1'b0)  begin errors++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy); end
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
        if (wr_drop !== 1'b0)   begin errors++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
        @(posedge clk); #1 rst_n = 1'b1;
        busy_cnt = 0; rise_at = -1;
        for (int c = 1; c <= D + 2; c++) begin
            idle();
            checks += 2;
            if (clr_busy !== (m_left > 0)) begin errors++; $display("FAIL init_busy c=%0d got=%b exp=%b", c, clr_busy, m_left > 0); end
            if (init_done !== m_done)      begin errors++; $display("FAIL init_done c=%0d got=%b exp=%b", c, init_done, m_done); end
            if (clr_busy === 1'b1) busy_cnt++;
            if (init_done === 1'b1 && rise_at < 0) rise_at = c;
        end
        checks += 2;
        if (busy_cnt != D)     begin errors++; $display("FAIL init_busy_len got=%0d exp=%0d", busy_cnt, D); end
        if (rise_at != D + 1)  begin errors++; $display("FAIL init_done_rise got=%0d exp=%0d", rise_at, D + 1); end
        for (int a = 0; a < D + LAT; a++) begin
            if (a < D) tick(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
            else       idle();
            checks += 2;
            if (rd_valid !== exp_valid) begin errors++; $display("FAIL init_rd_valid a=%0d got=%b exp=%b", a, rd_valid, exp_valid); end
            if (rd_data !== exp_data)   begin errors++; $display("FAIL init_rd_data a=%0d got=%h exp=%h", a, rd_data, exp_data); end
            if (a >= LAT - 1 && a < D + LAT - 1) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== INIT) begin errors++; $display("FAIL init_image a=%0d got=%h/%b exp=%h/1", a, rd_data, rd_valid, INIT); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int run, k;
        wait_ready();
        for (int a = 0; a < 10; a++) tick(1'b1, AW'(a), W'(a + 1), 1'b0, '0, 1'b0);
        run = 0; k = 0;
        for (int c = 0; c < 10 + LAT + 1; c++) begin
            if (c < 10) tick(1'b0, '0, '0, 1'b1, AW'(c), 1'b0);
            else        idle();
            checks += 2;
            if (rd_valid !== exp_valid) begin errors++; $display("FAIL b2b_rd_valid c=%0d got=%b exp=%b", c, rd_valid, exp_valid); end
            if (rd_data !== exp_data)   begin errors++; $display("FAIL b2b_rd_data c=%0d got=%h exp=%h", c, rd_data, exp_data); end
            if (rd_valid === 1'b1) begin
                checks++;
                if (rd_data !== W'(k + 1)) begin errors++; $display("FAIL b2b_order k=%0d got=%h exp=%h", k, rd_data, W'(k + 1)); end
                if (c != k + LAT - 1) begin errors++; $display("FAIL b2b_latency k=%0d got=%0d exp=%0d", k, c, k + LAT - 1); end
                k++; run++;
            end
        end
        checks++;
        if (run != 10) begin errors++; $display("FAIL b2b_run got=%0d exp=10", run); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 127)), W'($urandom),
                 ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 127)),
                 ($urandom_range(0, 149) == 0));
            checks += 5;
            if (rd_valid !== exp_valid)    begin errors++; $display("FAIL rnd_rd_valid c=%0d got=%b exp=%b", c, rd_valid, exp_valid); end
            if (rd_data !== exp_data)      begin errors++; $display("FAIL rnd_rd_data c=%0d got=%h exp=%h", c, rd_data, exp_data); end
            if (wr_drop !== exp_drop)      begin errors++; $display("FAIL rnd_wr_drop c=%0d got=%b exp=%b", c, wr_drop, exp_drop); end
            if (clr_busy !== (m_left > 0)) begin errors++; $display("FAIL rnd_clr_busy c=%0d got=%b exp=%b", c, clr_busy, m_left > 0); end
            if (init_done !== m_done)      begin errors++; $display("FAIL rnd_init_done c=%0d got=%b exp=%b", c, init_done, m_done); end
        end
    endtask

    task automatic test_clear_with_writes();
        int drops, low;
        wait_ready();
        tick(1'b1, AW'(5), 16'h1234, 1'b0, '0, 1'b1);
        drops = 0; low = (init_done === 1'b0) ? 1 : 0;
        for (int c = 0; c < D; c++) begin
            tick(1'b1, AW'($urandom_range(0, D - 1)), W'($urandom), ($urandom_range(0, 1) == 1),
                 AW'($urandom_range(0, D - 1)), ($urandom_range(0, 3) == 0));
            checks += 4;
            if (wr_drop !== 1'b1)        begin errors++; $display("FAIL clr_wr_drop c=%0d got=%b exp=1", c, wr_drop); end
            if (wr_drop !== exp_drop)    begin errors++; $display("FAIL clr_drop_model c=%0d got=%b exp=%b", c, wr_drop, exp_drop); end
            if (rd_data !== exp_data)    begin errors++; $display("FAIL clr_rd_data c=%0d got=%h exp=%h", c, rd_data, exp_data); end
            if (init_done !== m_done)    begin errors++; $display("FAIL clr_init_done c=%0d got=%b exp=%b", c, init_done, m_done); end
            if (wr_drop === 1'b1) drops++;
            if (init_done === 1'b0) low++;
        end
        checks += 2;
        if (drops != D) begin errors++; $display("FAIL clr_drop_count got=%0d exp=%0d", drops, D); end
        if (low != D)   begin errors++; $display("FAIL clr_done_low got=%0d exp=%0d", low, D); end
        tick(1'b0, '0, '0, 1'b1, AW'(5), 1'b0);
        for (int c = 0; c < LAT; c++) idle();
        checks += 2;
        if (wr_drop !== 1'b0) begin errors++; $display("FAIL clr_no_drop got=%b exp=0", wr_drop); end
        if (rd_data !== INIT) begin errors++; $display("FAIL clr_post_read got=%h exp=%h", rd_data, INIT); end
    endtask

    task automatic test_same_cycle();
        logic [W-1:0] want;
`ifdef SDPRAM_CLR_PIPE_WR_BYPASS_EN
        want = 16'h0ABC;
`else
        want = 16'h0111;
`endif
        wait_ready();
        tick(1'b1, AW'(7), 16'h0111, 1'b0, '0, 1'b0);
        tick(1'b1, AW'(7), 16'h0ABC, 1'b1, AW'(7), 1'b0);
        tick(1'b0, '0, '0, 1'b1, AW'(7), 1'b0);
        idle();
        checks += 2;
        if (rd_valid !== 1'b1 || rd_data !== want) begin errors++; $display("FAIL same_cycle got=%h/%b exp=%h/1", rd_data, rd_valid, want); end
        if (rd_data !== exp_data) begin errors++; $display("FAIL same_cycle_model got=%h exp=%h", rd_data, exp_data); end
        idle();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0ABC) begin errors++; $display("FAIL next_cycle_read got=%h/%b exp=0abc/1", rd_data, rd_valid); end
    endtask

    task automatic test_out_of_range();
        wait_ready();
        tick(1'b1, AW'(99), 16'h4242, 1'b0, '0, 1'b0);
        tick(1'b1, AW'(110), 16'h7777, 1'b1, AW'(110), 1'b0);
        checks++;
        if (wr_drop !== 1'b1) begin errors++; $display("FAIL oor_wr_drop got=%b exp=1", wr_drop); end
        tick(1'b0, '0, '0, 1'b1, AW'(99), 1'b0);
        checks++;
        if (wr_drop !== 1'b0) begin errors++; $display("FAIL oor_drop_once got=%b exp=0", wr_drop); end
        idle();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== INIT) begin errors++; $display("FAIL oor_read got=%h/%b exp=%h/1", rd_data, rd_valid, INIT); end
        idle();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h4242) begin errors++; $display("FAIL addr99_read got=%h/%b exp=4242/1", rd_data, rd_valid); end
    endtask

    task automatic test_reset_mid_clear();
        int busy_cnt;
        wait_ready();
        tick(1'b1, AW'(3), 16'hBEEF, 1'b0, '0, 1'b1);
        for (int c = 0; c < 49; c++) tick(1'b0, '0, '0, 1'b1, AW'(c), 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks += 5;
        if (rd_data !== '0)     begin errors++; $display("FAIL mid_rd_data got=%h exp=0", rd_data); end
        if (rd_valid !== 1'b0)  begin errors++; $display("FAIL mid_rd_valid got=%b exp=0", rd_valid); end
        if (clr_busy !== 1'b0)  begin errors++; $display("FAIL mid_clr_busy got=%b exp=0", clr_busy); end
        if (init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done got=%b exp=0", init_done); end
        if (wr_drop !== 1'b0)   begin errors++; $display("FAIL mid_wr_drop got=%b exp=0", wr_drop); end
        @(posedge clk); #1 rst_n = 1'b1;
        busy_cnt = 0;
        for (int c = 0; c < D + 2; c++) begin
            idle();
            checks += 2;
            if (clr_busy !== (m_left > 0)) begin errors++; $display("FAIL mid_busy c=%0d got=%b exp=%b", c, clr_busy, m_left > 0); end
            if (init_done !== m_done)      begin errors++; $display("FAIL mid_done c=%0d got=%b exp=%b", c, init_done, m_done); end
            if (clr_busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != D) begin errors++; $display("FAIL mid_busy_len got=%0d exp=%0d", busy_cnt, D); end
        for (int c = 0; c < 6 + LAT; c++) begin
            if (c < 6) tick(1'b0, '0, '0, 1'b1, AW'(c * 19), 1'b0);
            else       idle();
            checks++;
            if (rd_data !== exp_data || rd_valid !== exp_valid) begin
                errors++; $display("FAIL mid_post_read c=%0d got=%h/%b exp=%h/%b", c, rd_data, rd_valid, exp_data, exp_valid);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_random();
        test_clear_with_writes();
        test_same_cycle();
        test_out_of_range();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
